// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the memory loader: state encoding,
// address strides and the helpers used to skip empty phases and form
// byte addresses.
package mem_loader_pkg;

    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LD_I  = 3'd1,
        ST_LD_D  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DP_RD = 3'd4,
        ST_DP_WT = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Starting from phase s, step over every phase whose count is zero so that
    // an empty phase is never actually occupied.
    function automatic state_t skip_empty(input state_t s,
                                          input logic   imem_zero,
                                          input logic   dmem_zero,
                                          input logic   run_zero,
                                          input logic   dump_zero);
        state_t n;
        n = s;
        if (n == ST_LD_I  && imem_zero) n = ST_LD_D;
        if (n == ST_LD_D  && dmem_zero) n = ST_RUN;
        if (n == ST_RUN   && run_zero)  n = ST_DP_RD;
        if (n == ST_DP_RD && dump_zero) n = ST_DONE;
        return n;
    endfunction

    // Word index (already zero-extended) to byte address.
    function automatic logic [63:0] byte_addr(input logic [63:0] idx,
                                              input int          stride);
        return idx * 64'(stride);
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Load stream, dump stream and the two external memory ports of the cpu,
// bundled so the loader and its host see one connection.
interface mem_loader_if;

    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;

    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;

    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;

    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  s_valid, s_data, m_ready, rdata_ext_2,
        output s_ready, m_valid, m_data,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output s_valid, s_data, m_ready, rdata_ext_2,
        input  s_ready, m_valid, m_data,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

endinterface

// File: rtl/mem_loader_reg_arstn_en.sv
// Generic register with asynchronous active-low clear and load enable.
module reg_arstn_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise load d whenever enabled.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_loader.sv
// Host-side initiator for the cpu external memory ports: loads imem and dmem
// from a stream, runs the core for a fixed number of cycles, then streams
// dmem back out. All memory-side outputs are registered, so each strobe
// appears one cycle after the state that requested it; this keeps cpu_enable
// clear of the trailing write of the last load beat and of the dump reads.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RUN_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [CNT_W-1:0] dump_words,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    mem_loader_if.master     bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] imem_cnt_q, imem_cnt_d, dmem_cnt_q, dmem_cnt_d, dump_cnt_q, dump_cnt_d;
    logic [RUN_W-1:0] run_len_q, run_len_d, run_cnt_q, run_cnt_d;

    logic s_ready, start_acc, accept, last_i, last_d, last_run, dump_hs, last_dump;
    logic wen_ext_d, wen_ext_2_d, ren_ext_2_d, cpu_enable_d, rd_pend_d, m_valid_d;
    logic wen_ext_q, wen_ext_2_q, ren_ext_2_q, cpu_enable_q, rd_pend_q, m_valid_q;
    logic [5:0]  ctrl_d, ctrl_q;
    logic        imem_wr_en, dmem_addr_en, dmem_wr_en;
    logic [63:0] addr_ext_d, addr_ext_q, addr_ext_2_d, addr_ext_2_q;
    logic [31:0] wdata_ext_q;
    logic [63:0] wdata_ext_2_q, m_data_q;

    assign start_acc = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept    = bus.s_valid && s_ready;
    assign last_i    = (state_q == ST_LD_I) && accept && (idx_q == imem_cnt_q - CNT_W'(1));
    assign last_d    = (state_q == ST_LD_D) && accept && (idx_q == dmem_cnt_q - CNT_W'(1));
    assign last_run  = (state_q == ST_RUN) && (run_cnt_q == run_len_q - RUN_W'(1));
    assign dump_hs   = (state_q == ST_DP_WT) && m_valid_q && bus.m_ready;
    assign last_dump = dump_hs && (idx_q == dump_cnt_q - CNT_W'(1));

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: advance phase on its last event, skipping empty phases.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE:
                if (start) state_d = skip_empty(ST_LD_I, imem_words == '0, dmem_words == '0,
                                                run_cycles == '0, dump_words == '0);
            ST_LD_I:
                if (last_i) state_d = skip_empty(ST_LD_D, 1'b0, dmem_cnt_q == '0,
                                                 run_len_q == '0, dump_cnt_q == '0);
            ST_LD_D:
                if (last_d) state_d = skip_empty(ST_RUN, 1'b0, 1'b0,
                                                 run_len_q == '0, dump_cnt_q == '0);
            ST_RUN:
                if (last_run) state_d = skip_empty(ST_DP_RD, 1'b0, 1'b0, 1'b0, dump_cnt_q == '0);
            ST_DP_RD:
                state_d = ST_DP_WT;
            ST_DP_WT:
                if (dump_hs) state_d = last_dump ? ST_DONE : ST_DP_RD;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Counts latched on start, word index and run cycle counter.
    always_comb begin
        idx_d      = idx_q;
        imem_cnt_d = imem_cnt_q;
        dmem_cnt_d = dmem_cnt_q;
        dump_cnt_d = dump_cnt_q;
        run_len_d  = run_len_q;
        run_cnt_d  = run_cnt_q;
        if (start_acc) begin
            imem_cnt_d = imem_words;
            dmem_cnt_d = dmem_words;
            dump_cnt_d = dump_words;
            run_len_d  = run_cycles;
            run_cnt_d  = '0;
            idx_d      = '0;
        end else if (accept) begin
            idx_d = (last_i || last_d) ? '0 : idx_q + CNT_W'(1);
        end else if (state_q == ST_RUN) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end else if (dump_hs) begin
            idx_d = idx_q + CNT_W'(1);
        end
    end

    // Datapath registers that are not outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx_q      <= '0;
            imem_cnt_q <= '0;
            dmem_cnt_q <= '0;
            dump_cnt_q <= '0;
            run_len_q  <= '0;
            run_cnt_q  <= '0;
        end else begin
            idx_q      <= idx_d;
            imem_cnt_q <= imem_cnt_d;
            dmem_cnt_q <= dmem_cnt_d;
            dump_cnt_q <= dump_cnt_d;
            run_len_q  <= run_len_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    // Outputs: status decode plus next values of the registered strobes.
    always_comb begin
        s_ready      = (state_q == ST_LD_I) || (state_q == ST_LD_D);
        busy         = !(state_q == ST_IDLE || state_q == ST_DONE);
        done         = (state_q == ST_DONE);
        wen_ext_d    = accept && (state_q == ST_LD_I);
        wen_ext_2_d  = accept && (state_q == ST_LD_D);
        ren_ext_2_d  = (state_q == ST_DP_RD);
        cpu_enable_d = (state_q == ST_RUN);
        rd_pend_d    = ren_ext_2_q;
        m_valid_d    = m_valid_q;
        if (rd_pend_q)                      m_valid_d = 1'b1;
        else if (m_valid_q && bus.m_ready)  m_valid_d = 1'b0;
        imem_wr_en   = wen_ext_d;
        dmem_wr_en   = wen_ext_2_d;
        dmem_addr_en = wen_ext_2_d || ren_ext_2_d;
        addr_ext_d   = byte_addr(64'(idx_q), IMEM_STRIDE);
        addr_ext_2_d = byte_addr(64'(idx_q), DMEM_STRIDE);
    end

    assign ctrl_d = {wen_ext_d, wen_ext_2_d, ren_ext_2_d, cpu_enable_d, rd_pend_d, m_valid_d};
    assign {wen_ext_q, wen_ext_2_q, ren_ext_2_q, cpu_enable_q, rd_pend_q, m_valid_q} = ctrl_q;

    reg_arstn_en #(.W(6))  u_ctrl   (.clk(clk), .arst_n(arst_n), .en(1'b1),
                                     .d(ctrl_d), .q(ctrl_q));
    reg_arstn_en #(.W(64)) u_iaddr  (.clk(clk), .arst_n(arst_n), .en(imem_wr_en),
                                     .d(addr_ext_d), .q(addr_ext_q));
    reg_arstn_en #(.W(32)) u_iwdata (.clk(clk), .arst_n(arst_n), .en(imem_wr_en),
                                     .d(bus.s_data[31:0]), .q(wdata_ext_q));
    reg_arstn_en #(.W(64)) u_daddr  (.clk(clk), .arst_n(arst_n), .en(dmem_addr_en),
                                     .d(addr_ext_2_d), .q(addr_ext_2_q));
    reg_arstn_en #(.W(64)) u_dwdata (.clk(clk), .arst_n(arst_n), .en(dmem_wr_en),
                                     .d(bus.s_data), .q(wdata_ext_2_q));
    reg_arstn_en #(.W(64)) u_mdata  (.clk(clk), .arst_n(arst_n), .en(rd_pend_q),
                                     .d(bus.rdata_ext_2), .q(m_data_q));

    assign bus.s_ready     = s_ready;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.addr_ext    = addr_ext_q;
    assign bus.wen_ext     = wen_ext_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.wdata_ext   = wdata_ext_q;
    assign bus.addr_ext_2  = addr_ext_2_q;
    assign bus.wen_ext_2   = wen_ext_2_q;
    assign bus.ren_ext_2   = ren_ext_2_q;
    assign bus.wdata_ext_2 = wdata_ext_2_q;
    assign cpu_enable      = cpu_enable_q;

endmodule
